// File: rtl/fitness_evaluator.sv
// Sweeps every input vector through an external evolved-circuit evaluator
// and counts the output bits that agree with a captured truth table.
module fitness_evaluator #(
  parameter  int IN  = 4,
  parameter  int OUT = 2,
  localparam int N   = 2 ** IN,
  localparam int TW  = N * OUT,
  localparam int FW  = $clog2(TW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [TW-1:0] target,
  output logic [IN-1:0] circ_inp,
  input  logic [OUT-1:0] circ_out,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] fitness,
  output logic          perfect
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [IN-1:0] cnt_q, cnt_d;
  logic [FW-1:0] acc_q, acc_d;
  logic [FW-1:0] fit_q, fit_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic          done_q, done_d;

  logic [OUT-1:0] tbl [N];
  logic [OUT-1:0] entry;
  logic [FW-1:0]  match;

  for (genvar g = 0; g < N; g++) begin : g_tbl
    assign tbl[g] = tgt_q[g*OUT +: OUT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      fit_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fit_q   <= fit_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP: begin
        if (abort)       state_d = IDLE;
        else if (&cnt_q) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bits of the evaluator output that agree with table entry cnt_q.
  always_comb begin
    entry = tbl[cnt_q];
    match = '0;
    for (int i = 0; i < OUT; i++) begin
      if (circ_out[i] == entry[i]) match = match + FW'(1);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    fit_d  = fit_q;
    tgt_d  = tgt_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d = target;
          cnt_d = '0;
          acc_d = '0;
        end
      end
      SWEEP: begin
        if (abort) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + IN'(1);
          acc_d = acc_q + match;
        end
      end
      FINISH: begin
        fit_d  = acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign circ_inp = cnt_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign fitness  = fit_q;
  assign perfect  = (fit_q == FW'(TW));

endmodule

// File: doc/fitness_evaluator.md
FITNESS_EVALUATOR -- requirements
Module: fitness_evaluator

Interface
REQ-001 The parameter IN SHALL default to 4 and set the number of circuit inputs.
REQ-002 The parameter OUT SHALL default to 2 and set the number of circuit outputs.
REQ-003 The derived width FW SHALL equal $clog2((2**IN)*OUT+1).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset, which is asynchronous and active-high.
REQ-006 Port start, input, 1 bit, SHALL request one evaluation sweep.
REQ-007 Port abort, input, 1 bit, SHALL cancel a sweep in progress.
REQ-008 Port target, input, (2**IN)*OUT bits, SHALL carry the desired truth table: entry k = target[k*OUT +: OUT].
REQ-009 Port circ_inp, output, IN bits, SHALL drive the inp port of the evolved-circuit evaluator.
REQ-010 Port circ_out, input, OUT bits, SHALL receive the evaluator's out port, combinational in circ_inp.
REQ-011 Port busy, output, 1 bit, SHALL be high while a sweep is in progress.
REQ-012 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-013 Port fitness, output, FW bits, SHALL hold the count of matching output bits from the last completed sweep.
REQ-014 Port perfect, output, 1 bit, SHALL be high when fitness equals (2**IN)*OUT.

Function
REQ-015 The FSM SHALL have three states: IDLE, SWEEP and FINISH.
REQ-016 In IDLE, if start=1 is sampled, the block SHALL:
- capture target into an internal register;
- clear the vector counter and the accumulator;
- enter SWEEP.
REQ-017 circ_inp SHALL always equal the registered vector counter (IN bits); it SHALL be 0 in IDLE.
REQ-018 In each SWEEP cycle with counter value k, the accumulator SHALL add the number of bit positions where circ_out equals captured-target entry k (0..OUT).
REQ-019 In each SWEEP cycle, the counter SHALL increment by 1.
REQ-020 The cycle with k = 2**IN-1 SHALL be the last SWEEP cycle; the next state SHALL be FINISH, and the counter SHALL wrap to 0 without extra effect.
REQ-021 In FINISH:
- fitness SHALL load the final accumulator value (including the last entry's contribution);
- done SHALL pulse high for exactly one cycle;
- the next state SHALL be IDLE.
REQ-022 Timing: with start sampled at edge 0, SWEEP SHALL occupy edges 1..2**IN, and done/updated fitness SHALL be visible after edge 2**IN+1.
REQ-023 busy SHALL be high in SWEEP and FINISH and low in IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Changes on target after capture SHALL NOT affect the running sweep.
REQ-026 abort=1 sampled in SWEEP SHALL return the FSM to IDLE on that edge, with no done pulse and fitness/perfect unchanged.
REQ-027 abort SHALL take priority over sweep completion in the same cycle.
REQ-028 abort in IDLE or FINISH SHALL have no effect.
REQ-029 If start and abort are both high in IDLE, start SHALL win.
REQ-030 The accumulator SHALL be FW bits wide and SHALL never overflow, since the maximum is (2**IN)*OUT.
REQ-031 perfect SHALL be combinational from fitness.

Reset
REQ-032 rst=1 SHALL immediately force the following, regardless of clk:
- state=IDLE;
- counter, accumulator, fitness = 0;
- captured target = 0;
- busy=0, done=0, perfect=0.
REQ-033 Reset asserted mid-sweep SHALL discard the sweep with no done pulse.
REQ-034 The first start after reset release SHALL behave per REQ-016.

Verification
REQ-035 With IN=4, OUT=2, a bench stub computing out = {^inp, &inp}, and target equal to that function, pulsing start SHALL give:
- busy for 17 cycles;
- done at edge 17;
- fitness=32, perfect=1.
REQ-036 With the same stub and target set to the bitwise inverse of the function, a sweep SHALL end with fitness=0 and perfect=0.
REQ-037 With the same stub and a target differing in exactly 3 bits, a sweep SHALL end with fitness=29; circ_inp SHALL step 0,1,...,15 on consecutive SWEEP cycles.
REQ-038 Asserting abort at SWEEP cycle 8 SHALL give:
- busy low on the next cycle;
- no done pulse;
- fitness still holding the prior result;
- a following start completing normally.
REQ-039 Re-pulsing start and toggling target during a sweep SHALL leave the result unchanged (matching the captured target), with exactly one done pulse.
REQ-040 Asserting rst asynchronously mid-sweep SHALL force all outputs to 0 before the next clk edge, with no done pulse.
